// File: rtl/ama_riscv_mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch (I) and load/store (D) share one
// valid/ready memory port, one transaction outstanding, D priority with I anti-starvation.
module ama_riscv_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req_valid,
  output logic            i_req_ready,
  input  logic [AW-1:0]   i_req_addr,
  output logic            i_rsp_valid,
  input  logic            i_rsp_ready,
  input  logic            d_req_valid,
  output logic            d_req_ready,
  input  logic [AW-1:0]   d_req_addr,
  input  logic [DW-1:0]   d_req_wdata,
  input  logic [DW/8-1:0] d_req_wstrb,
  output logic            d_rsp_valid,
  input  logic            d_rsp_ready,
  output logic [DW-1:0]   rsp_data,
  output logic            m_req_valid,
  input  logic            m_req_ready,
  output logic [AW-1:0]   m_req_addr,
  output logic [DW-1:0]   m_req_wdata,
  output logic [DW/8-1:0] m_req_wstrb,
  input  logic            m_rsp_valid,
  output logic            m_rsp_ready,
  input  logic [DW-1:0]   m_rsp_data
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {IDLE, REQ_I, REQ_D, WAIT_I, WAIT_D} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   starve_q, starve_d;
  logic            sel_i, sel_d;
  logic            starved;

  assign starved = (starve_q == CW'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    sel_i       = 1'b0;
    sel_d       = 1'b0;
    i_req_ready = 1'b0;
    d_req_ready = 1'b0;
    i_rsp_valid = 1'b0;
    d_rsp_valid = 1'b0;
    m_req_valid = 1'b0;
    m_req_addr  = '0;
    m_req_wdata = '0;
    m_req_wstrb = '0;
    m_rsp_ready = 1'b0;
    rsp_data    = m_rsp_data;

    case (state_q)
      IDLE: begin
        if (i_req_valid && (!d_req_valid || starved)) sel_i = 1'b1;
        else if (d_req_valid)                         sel_d = 1'b1;
      end
      REQ_I: sel_i = 1'b1;
      REQ_D: sel_d = 1'b1;
      WAIT_I: begin
        i_rsp_valid = m_rsp_valid;
        m_rsp_ready = i_rsp_ready;
        if (m_rsp_valid && i_rsp_ready) state_d = IDLE;
      end
      WAIT_D: begin
        d_rsp_valid = m_rsp_valid;
        m_rsp_ready = d_rsp_ready;
        if (m_rsp_valid && d_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Once presented, the grant is held in REQ_x until the memory takes it.
    if (sel_i) begin
      m_req_valid = 1'b1;
      m_req_addr  = i_req_addr;
      i_req_ready = m_req_ready;
      state_d     = m_req_ready ? WAIT_I : REQ_I;
      if (m_req_ready) starve_d = '0;
    end
    if (sel_d) begin
      m_req_valid = 1'b1;
      m_req_addr  = d_req_addr;
      m_req_wdata = d_req_wdata;
      m_req_wstrb = d_req_wstrb;
      d_req_ready = m_req_ready;
      state_d     = m_req_ready ? WAIT_D : REQ_D;
      if (m_req_ready && i_req_valid && !starved) starve_d = starve_q + 1'b1;
    end

    if (!rst) begin
      i_req_ready = 1'b0;
      d_req_ready = 1'b0;
      i_rsp_valid = 1'b0;
      d_rsp_valid = 1'b0;
      m_req_valid = 1'b0;
      m_req_addr  = '0;
      m_req_wdata = '0;
      m_req_wstrb = '0;
      m_rsp_ready = 1'b0;
      rsp_data    = '0;
    end
  end

endmodule

// File: tb/tb_ama_riscv_mem_arbiter.sv
// Scoreboard bench for ama_riscv_mem_arbiter: requester drivers push expectations,
// a negedge monitor pops and compares on every request/response handshake.
module tb_ama_riscv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_ready;
  logic [31:0] i_req_addr;
  logic        d_req_valid, d_req_ready, d_rsp_valid, d_rsp_ready;
  logic [31:0] d_req_addr, d_req_wdata;
  logic [3:0]  d_req_wstrb;
  logic [31:0] rsp_data;
  logic        m_req_valid, m_req_ready, m_rsp_valid, m_rsp_ready;
  logic [31:0] m_req_addr, m_req_wdata, m_rsp_data;
  logic [3:0]  m_req_wstrb;

  always #5 clk = ~clk;

  ama_riscv_mem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready),
    .rsp_data(rsp_data),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_data(m_rsp_data)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } cmd_t;

  cmd_t        i_cmd_q[$], d_cmd_q[$], i_req_exp[$], d_req_exp[$];
  logic [31:0] i_rsp_exp[$], d_rsp_exp[$];
  string       grant_log = "";
  int          total = 0, bad = 0;
  bit          mem_auto = 1'b1;
  bit          force_vld = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endfunction

  function automatic void chk_str(string name, string act, string exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%s want=%s", name, act, exp);
    end
  endfunction

  function automatic void fail1(string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected handshake, nothing expected", name);
  endfunction

  // Memory: answers one cycle after acceptance; data derived from the address.
  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a == 32'h40) ? 32'h0000_0013 : {a[15:0], 16'hC0DE};
  endfunction

  initial begin
    bit rf, af;
    logic [31:0] a;
    m_rsp_valid = 1'b0;
    m_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      rf = m_req_valid && m_req_ready;
      af = m_rsp_valid && m_rsp_ready;
      a  = m_req_addr;
      @(posedge clk); #1;
      if (mem_auto) begin
        if (af) m_rsp_valid = 1'b0;
        if (rf) begin
          m_rsp_valid = 1'b1;
          m_rsp_data  = mem_word(a);
        end
      end else begin
        m_rsp_valid = force_vld;
        m_rsp_data  = 32'h0000_0BAD;
      end
    end
  end

  // I requester driver
  initial begin
    cmd_t c;
    bit acc;
    i_req_valid = 1'b0;
    i_req_addr  = 32'h0;
    forever begin
      @(negedge clk);
      acc = i_req_valid && i_req_ready;
      @(posedge clk); #1;
      if (acc) i_req_valid = 1'b0;
      if (!i_req_valid && i_cmd_q.size() > 0) begin
        c = i_cmd_q.pop_front();
        i_req_valid = 1'b1;
        i_req_addr  = c.addr;
        i_req_exp.push_back(c);
        i_rsp_exp.push_back(c.rdata);
      end
    end
  end

  // D requester driver; holds valid back-to-back when commands are queued
  initial begin
    cmd_t c;
    bit acc;
    d_req_valid = 1'b0;
    d_req_addr  = 32'h0;
    d_req_wdata = 32'h0;
    d_req_wstrb = 4'h0;
    forever begin
      @(negedge clk);
      acc = d_req_valid && d_req_ready;
      @(posedge clk); #1;
      if (acc) d_req_valid = 1'b0;
      if (!d_req_valid && d_cmd_q.size() > 0) begin
        c = d_cmd_q.pop_front();
        d_req_valid = 1'b1;
        d_req_addr  = c.addr;
        d_req_wdata = c.wdata;
        d_req_wstrb = c.wstrb;
        d_req_exp.push_back(c);
        d_rsp_exp.push_back(c.rdata);
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    cmd_t e;
    if (i_req_valid && i_req_ready) begin
      grant_log = {grant_log, "I"};
      if (i_req_exp.size() == 0) fail1("i_req");
      else begin
        e = i_req_exp.pop_front();
        chk("i_req m_req_valid", {31'h0, m_req_valid}, 32'h1);
        chk("i_req m_req_addr", m_req_addr, e.addr);
        chk("i_req m_req_wdata", m_req_wdata, 32'h0);
        chk("i_req m_req_wstrb", {28'h0, m_req_wstrb}, 32'h0);
      end
    end
    if (d_req_valid && d_req_ready) begin
      grant_log = {grant_log, "D"};
      if (d_req_exp.size() == 0) fail1("d_req");
      else begin
        e = d_req_exp.pop_front();
        chk("d_req m_req_valid", {31'h0, m_req_valid}, 32'h1);
        chk("d_req m_req_addr", m_req_addr, e.addr);
        chk("d_req m_req_wdata", m_req_wdata, e.wdata);
        chk("d_req m_req_wstrb", {28'h0, m_req_wstrb}, {28'h0, e.wstrb});
      end
    end
    if (i_req_ready && d_req_ready) fail1("both_req_ready");
    if (i_rsp_valid && d_rsp_valid) fail1("both_rsp_valid");
    if (i_rsp_valid && i_rsp_ready) begin
      if (i_rsp_exp.size() == 0) fail1("i_rsp");
      else chk("i_rsp rsp_data", rsp_data, i_rsp_exp.pop_front());
    end
    if (d_rsp_valid && d_rsp_ready) begin
      if (d_rsp_exp.size() == 0) fail1("d_rsp");
      else chk("d_rsp rsp_data", rsp_data, d_rsp_exp.pop_front());
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic drain(string name);
    int n = 0;
    while ((i_cmd_q.size() > 0 || d_cmd_q.size() > 0 || i_rsp_exp.size() > 0 ||
            d_rsp_exp.size() > 0 || i_req_valid || d_req_valid) && n < 200) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL %s: drain timeout after %0d cycles", name, n);
    end
    step();
  endtask

  task automatic push_i(logic [31:0] a, logic [31:0] r);
    cmd_t c;
    c.addr = a; c.wdata = 32'h0; c.wstrb = 4'h0; c.rdata = r;
    i_cmd_q.push_back(c);
  endtask

  task automatic push_d(logic [31:0] a, logic [31:0] w, logic [3:0] s, logic [31:0] r);
    cmd_t c;
    c.addr = a; c.wdata = w; c.wstrb = s; c.rdata = r;
    d_cmd_q.push_back(c);
  endtask

  initial begin
    int n;
    rst         = 1'b0;
    m_req_ready = 1'b1;
    i_rsp_ready = 1'b1;
    d_rsp_ready = 1'b1;

    // Reset: a pending fetch must see no ready while rst is low
    push_i(32'h40, 32'h0000_0013);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst handshake outs",
        {26'h0, i_req_ready, d_req_ready, m_req_valid, m_rsp_ready, i_rsp_valid, d_rsp_valid}, 32'h0);
    chk("rst m_req_addr", m_req_addr, 32'h0);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("single fetch i_req_ready", {31'h0, i_req_ready}, 32'h1);
    chk("single fetch m_req_addr", m_req_addr, 32'h40);
    drain("single fetch");
    chk_str("single fetch grants", grant_log, "I");

    // Simultaneous I and D: D first
    grant_log = "";
    push_i(32'h80, 32'h0080_C0DE);
    push_d(32'h100, 32'h0, 4'h0, 32'h0100_C0DE);
    drain("simultaneous");
    chk_str("simultaneous grants", grant_log, "DI");

    // Starvation: I forced after four D grants
    grant_log = "";
    push_i(32'h84, 32'h0084_C0DE);
    push_d(32'h300, 32'h0, 4'h0, 32'h0300_C0DE);
    push_d(32'h304, 32'h0, 4'h0, 32'h0304_C0DE);
    push_d(32'h308, 32'h0, 4'h0, 32'h0308_C0DE);
    push_d(32'h30C, 32'h0, 4'h0, 32'h030C_C0DE);
    push_d(32'h310, 32'h0, 4'h0, 32'h0310_C0DE);
    push_d(32'h314, 32'h0, 4'h0, 32'h0314_C0DE);
    drain("starve1");
    chk_str("starve1 grants", grant_log, "DDDDIDD");

    // Counter must have cleared: the full four D grants happen again
    grant_log = "";
    push_i(32'h8C, 32'h008C_C0DE);
    push_d(32'h320, 32'h0, 4'h0, 32'h0320_C0DE);
    push_d(32'h324, 32'h0, 4'h0, 32'h0324_C0DE);
    push_d(32'h328, 32'h0, 4'h0, 32'h0328_C0DE);
    push_d(32'h32C, 32'h0, 4'h0, 32'h032C_C0DE);
    push_d(32'h330, 32'h0, 4'h0, 32'h0330_C0DE);
    drain("starve2");
    chk_str("starve2 grants", grant_log, "DDDDID");

    // Memory stall: D grant locked while I arrives
    grant_log = "";
    m_req_ready = 1'b0;
    push_d(32'h400, 32'h1122_3344, 4'hF, 32'h0400_C0DE);
    step();
    push_i(32'h88, 32'h0088_C0DE);
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall i_req_ready", {31'h0, i_req_ready}, 32'h0);
      chk("stall m_req_valid", {31'h0, m_req_valid}, 32'h1);
      chk("stall m_req_addr", m_req_addr, 32'h400);
      chk("stall m_req_wdata", m_req_wdata, 32'h1122_3344);
    end
    step();
    m_req_ready = 1'b1;
    drain("stall");
    chk_str("stall grants", grant_log, "DI");

    // Store with byte strobes; fetch-side response ready must not matter
    grant_log = "";
    i_rsp_ready = 1'b0;
    push_d(32'h200, 32'hDEAD_BEEF, 4'b0011, 32'h0200_C0DE);
    drain("store");
    chk_str("store grants", grant_log, "D");
    i_rsp_ready = 1'b1;

    // Load response backpressure
    d_rsp_ready = 1'b0;
    push_d(32'h500, 32'h0, 4'h0, 32'h0500_C0DE);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_rsp_valid && n < 20);
    chk("bp d_rsp_valid", {31'h0, d_rsp_valid}, 32'h1);
    chk("bp m_rsp_ready", {31'h0, m_rsp_ready}, 32'h0);
    @(negedge clk);
    chk("bp d_rsp_valid held", {31'h0, d_rsp_valid}, 32'h1);
    step();
    d_rsp_ready = 1'b1;
    drain("backpressure");

    // Reset while in WAIT_D with a response pending
    mem_auto    = 1'b0;
    d_rsp_ready = 1'b0;
    push_d(32'h600, 32'h0, 4'h0, 32'h0600_C0DE);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(d_req_valid && d_req_ready) && n < 20);
    chk("rstw d accepted", {31'h0, d_req_ready}, 32'h1);
    force_vld = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rstw outs",
        {26'h0, i_req_ready, d_req_ready, m_req_valid, m_rsp_ready, i_rsp_valid, d_rsp_valid}, 32'h0);
    chk("rstw m_req_addr", m_req_addr, 32'h0);
    step();
    rst = 1'b1;
    d_rsp_ready = 1'b1;
    @(negedge clk);
    chk("stale m_rsp_ready", {31'h0, m_rsp_ready}, 32'h0);
    chk("stale d_rsp_valid", {31'h0, d_rsp_valid}, 32'h0);
    step();
    force_vld = 1'b0;
    step();
    step();
    d_rsp_exp.delete();
    mem_auto = 1'b1;

    grant_log = "";
    push_i(32'h40, 32'h0000_0013);
    drain("post reset fetch");
    chk_str("post reset grants", grant_log, "I");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
